// File: rtl/local_hist_predictor_pkg.sv
// LocalPredTypes: shared types and helpers for the local-history predictor.
// The typedefs describe the default table geometry. The index and saturation
// helpers take explicit widths, so any parameterisation of the predictor can
// use them.
package LocalPredTypes;

  localparam int DEF_BHT_INDEX_BITS = 8;
  localparam int DEF_PHT_INDEX_BITS = 10;
  localparam int DEF_HIST_LEN       = 4;
  localparam int DEF_CNT_WIDTH      = 2;

  typedef logic [DEF_BHT_INDEX_BITS-1:0] BhtIndexPath;
  typedef logic [DEF_PHT_INDEX_BITS-1:0] PhtIndexPath;
  typedef logic [DEF_HIST_LEN-1:0]       LocalHistPath;
  typedef logic [DEF_CNT_WIDTH-1:0]      PhtCounter;

  typedef enum logic {
    INIT_ST  = 1'b0,
    READY_ST = 1'b1
  } InitState;

  // BHT index: the instruction-aligned PC bits just above the byte offset.
  function automatic logic [31:0] ToBhtIndex(input logic [63:0] pc, input int shift,
                                              input int bits);
    return 32'((pc >> shift) & ((64'd1 << bits) - 64'd1));
  endfunction

  // PHT index: the low PC bits concatenated above the local history.
  function automatic logic [31:0] ToPhtIndex(input logic [63:0] pc, input logic [31:0] hist,
                                              input int shift, input int pht_bits,
                                              input int hist_len);
    return 32'((((pc >> shift) & ((64'd1 << (pht_bits - hist_len)) - 64'd1)) << hist_len)
               | {32'd0, hist});
  endfunction

  function automatic logic [31:0] SatInc(input logic [31:0] cnt, input int width);
    return (cnt >= ((32'd1 << width) - 32'd1)) ? ((32'd1 << width) - 32'd1) : cnt + 32'd1;
  endfunction

  function automatic logic [31:0] SatDec(input logic [31:0] cnt);
    return (cnt == 32'd0) ? 32'd0 : cnt - 32'd1;
  endfunction

endpackage

// File: rtl/local_hist_predictor_init.sv
// local_pred_init_seq: INIT/READY sequencer for the predictor tables.
// After rst it walks initIdx from 0 to INIT_CYCLES-1, one entry per cycle,
// and then parks in READY until the next rst.
// Ports: clk, rst (sync, active high); initBusy (INIT in progress);
//        initWE (table init write this cycle); initIdx (entry being written).
module local_pred_init_seq
  import LocalPredTypes::*;
#(
  parameter int INIT_CYCLES = 1024,
  parameter int IDX_W       = $clog2(INIT_CYCLES)
) (
  input  logic             clk,
  input  logic             rst,
  output logic             initBusy,
  output logic             initWE,
  output logic [IDX_W-1:0] initIdx
);

  InitState         state_reg, state_next;
  logic [IDX_W-1:0] idx_reg, idx_next;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= INIT_ST;
      idx_reg   <= '0;
    end else begin
      state_reg <= state_next;
      idx_reg   <= idx_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    idx_next   = idx_reg;
    initBusy   = 1'b0;
    initWE     = 1'b0;
    case (state_reg)
      INIT_ST: begin
        initBusy = 1'b1;
        initWE   = 1'b1;
        idx_next = idx_reg + 1'b1;
        if (idx_reg == IDX_W'(INIT_CYCLES - 1)) begin
          state_next = READY_ST;
          idx_next   = '0;
        end
      end
      default: ;
    endcase
  end

  assign initIdx = idx_reg;

endmodule

// File: rtl/local_hist_predictor.sv
// local_hist_predictor: per-address two-level branch direction predictor.
// A BHT of per-PC local histories selects a saturating counter in the PHT.
// Ports: clk, rst; initBusy; predValid/predPC/predCondBr in, registered
// predOutValid/predTaken/predHist/predCnt out one cycle later; UPDATE_WIDTH
// resolution lanes updValid/updPC/updTaken/updMispred/updHist/updCnt.
// Optional macro LOCAL_PRED_STATS_EN adds statPredNum/statMispredNum counters.
module local_hist_predictor
  import LocalPredTypes::*;
#(
  parameter int FETCH_WIDTH    = 2,
  parameter int UPDATE_WIDTH   = 2,
  parameter int BHT_INDEX_BITS = 8,
  parameter int HIST_LEN       = 4,
  parameter int PHT_INDEX_BITS = 10,
  parameter int CNT_WIDTH      = 2,
  parameter int PC_WIDTH       = 32,
  parameter int INSN_SHIFT     = 2
) (
  input  logic                             clk,
  input  logic                             rst,
  output logic                             initBusy,
  input  logic                             predValid,
  input  logic [PC_WIDTH-1:0]              predPC,
  input  logic [FETCH_WIDTH-1:0]           predCondBr,
  output logic                             predOutValid,
  output logic [FETCH_WIDTH-1:0]           predTaken,
  output logic [FETCH_WIDTH*HIST_LEN-1:0]  predHist,
  output logic [FETCH_WIDTH*CNT_WIDTH-1:0] predCnt,
`ifdef LOCAL_PRED_STATS_EN
  output logic [31:0]                      statPredNum,
  output logic [31:0]                      statMispredNum,
`endif
  input  logic [UPDATE_WIDTH-1:0]          updValid,
  input  logic [UPDATE_WIDTH*PC_WIDTH-1:0] updPC,
  input  logic [UPDATE_WIDTH-1:0]          updTaken,
  input  logic [UPDATE_WIDTH-1:0]          updMispred,
  input  logic [UPDATE_WIDTH*HIST_LEN-1:0] updHist,
  input  logic [UPDATE_WIDTH*CNT_WIDTH-1:0] updCnt
);

  localparam int PHT_SIZE    = 1 << PHT_INDEX_BITS;
  localparam int BHT_SIZE    = 1 << BHT_INDEX_BITS;
  localparam int INIT_CYCLES = (PHT_SIZE > BHT_SIZE) ? PHT_SIZE : BHT_SIZE;
  localparam int IDX_W       = $clog2(INIT_CYCLES);
  localparam logic [CNT_WIDTH-1:0] CNT_INIT = {1'b1, {(CNT_WIDTH-1){1'b0}}};

  logic [CNT_WIDTH-1:0] pht [PHT_SIZE];
  logic [HIST_LEN-1:0]  bht [BHT_SIZE];

  logic             init_busy, init_we;
  logic [IDX_W-1:0] init_idx;

  local_pred_init_seq #(.INIT_CYCLES(INIT_CYCLES), .IDX_W(IDX_W)) u_init (
    .clk      (clk),
    .rst      (rst),
    .initBusy (init_busy),
    .initWE   (init_we),
    .initIdx  (init_idx)
  );

  assign initBusy = init_busy;

  logic pred_fire;
  assign pred_fire = predValid & ~init_busy;

  // Per-slot lookup.
  logic [PC_WIDTH-1:0]       slot_pc       [FETCH_WIDTH];
  logic [BHT_INDEX_BITS-1:0] slot_bidx     [FETCH_WIDTH];
  logic [HIST_LEN-1:0]       slot_hist     [FETCH_WIDTH];
  logic [HIST_LEN-1:0]       slot_new_hist [FETCH_WIDTH];
  logic [CNT_WIDTH-1:0]      slot_cnt      [FETCH_WIDTH];
  logic [FETCH_WIDTH-1:0]    slot_taken, slot_shift;
  logic                      taken_seen;

  // Update lanes.
  logic [PHT_INDEX_BITS-1:0] upd_pidx     [UPDATE_WIDTH];
  logic [BHT_INDEX_BITS-1:0] upd_bidx     [UPDATE_WIDTH];
  logic [CNT_WIDTH-1:0]      upd_new_cnt  [UPDATE_WIDTH];
  logic [HIST_LEN-1:0]       upd_new_hist [UPDATE_WIDTH];

  genvar gi;
  generate
    for (gi = 0; gi < FETCH_WIDTH; gi++) begin : g_slot
      assign slot_pc[gi]   = predPC + (PC_WIDTH'(gi) << INSN_SHIFT);
      assign slot_bidx[gi] = BHT_INDEX_BITS'(ToBhtIndex(64'(slot_pc[gi]), INSN_SHIFT,
                                                        BHT_INDEX_BITS));
    end
    for (gi = 0; gi < UPDATE_WIDTH; gi++) begin : g_lane
      logic [PC_WIDTH-1:0]  lane_pc;
      logic [HIST_LEN-1:0]  lane_hist;
      logic [CNT_WIDTH-1:0] lane_cnt;
      assign lane_pc       = updPC[gi*PC_WIDTH +: PC_WIDTH];
      assign lane_hist     = updHist[gi*HIST_LEN +: HIST_LEN];
      assign lane_cnt      = updCnt[gi*CNT_WIDTH +: CNT_WIDTH];
      assign upd_bidx[gi]  = BHT_INDEX_BITS'(ToBhtIndex(64'(lane_pc), INSN_SHIFT,
                                                        BHT_INDEX_BITS));
      assign upd_pidx[gi]  = PHT_INDEX_BITS'(ToPhtIndex(64'(lane_pc), 32'(lane_hist),
                                                        INSN_SHIFT, PHT_INDEX_BITS, HIST_LEN));
      assign upd_new_cnt[gi] = updTaken[gi] ? CNT_WIDTH'(SatInc(32'(lane_cnt), CNT_WIDTH))
                                            : CNT_WIDTH'(SatDec(32'(lane_cnt)));
      assign upd_new_hist[gi] = {lane_hist[HIST_LEN-2:0], updTaken[gi]};
    end
  endgenerate

  // Slots are walked in fetch order. A slot whose BHT entry was already
  // shifted by an earlier slot in this group sees that shifted history, and
  // shifting stops after the first slot predicted taken.
  always_comb begin
    taken_seen = 1'b0;
    slot_taken = '0;
    slot_shift = '0;
    for (int i = 0; i < FETCH_WIDTH; i++) begin
      slot_hist[i]     = '0;
      slot_new_hist[i] = '0;
      slot_cnt[i]      = '0;
    end
    for (int i = 0; i < FETCH_WIDTH; i++) begin
      slot_hist[i] = bht[slot_bidx[i]];
      for (int j = 0; j < FETCH_WIDTH; j++) begin
        if (j < i && slot_shift[j] && slot_bidx[j] == slot_bidx[i])
          slot_hist[i] = slot_new_hist[j];
      end
      slot_cnt[i] = pht[PHT_INDEX_BITS'(ToPhtIndex(64'(slot_pc[i]), 32'(slot_hist[i]),
                                                   INSN_SHIFT, PHT_INDEX_BITS, HIST_LEN))];
      slot_taken[i]    = slot_cnt[i][CNT_WIDTH-1] & predCondBr[i];
      slot_shift[i]    = predCondBr[i] & ~taken_seen;
      slot_new_hist[i] = {slot_hist[i][HIST_LEN-2:0], slot_taken[i]};
      taken_seen       = taken_seen | slot_taken[i];
    end
  end

  // Table writes. Later non-blocking assignments win, which gives the
  // required priorities: in the PHT lanes are walked downwards so lane 0
  // wins; in the BHT recoveries follow the speculative shifts and are
  // walked upwards so the highest recovering lane wins.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (init_we) begin
        if (int'(init_idx) < PHT_SIZE) pht[PHT_INDEX_BITS'(init_idx)] <= CNT_INIT;
        if (int'(init_idx) < BHT_SIZE) bht[BHT_INDEX_BITS'(init_idx)] <= '0;
      end else begin
        if (predValid) begin
          for (int i = 0; i < FETCH_WIDTH; i++)
            if (slot_shift[i]) bht[slot_bidx[i]] <= slot_new_hist[i];
        end
        for (int k = UPDATE_WIDTH - 1; k >= 0; k--)
          if (updValid[k]) pht[upd_pidx[k]] <= upd_new_cnt[k];
        for (int k = 0; k < UPDATE_WIDTH; k++)
          if (updValid[k] && updMispred[k]) bht[upd_bidx[k]] <= upd_new_hist[k];
      end
    end
  end

  // Registered prediction outputs; values hold when no request was accepted.
  always_ff @(posedge clk) begin
    if (rst) begin
      predOutValid <= 1'b0;
      predTaken    <= '0;
      predHist     <= '0;
      predCnt      <= '0;
    end else begin
      predOutValid <= pred_fire;
      if (pred_fire) begin
        predTaken <= slot_taken;
        for (int i = 0; i < FETCH_WIDTH; i++) begin
          predHist[i*HIST_LEN +: HIST_LEN]  <= slot_hist[i];
          predCnt[i*CNT_WIDTH +: CNT_WIDTH] <= slot_cnt[i];
        end
      end
    end
  end

`ifdef LOCAL_PRED_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      statPredNum    <= '0;
      statMispredNum <= '0;
    end else if (!init_busy) begin
      if (predValid) statPredNum <= statPredNum + 32'($countones(predCondBr));
      statMispredNum <= statMispredNum + 32'($countones(updValid & updMispred));
    end
  end
`endif

endmodule

// File: tb/tb_local_hist_predictor.sv
// Self-checking bench for local_hist_predictor: directed steps plus random
// traffic checked against an array-based reference model.
module tb_local_hist_predictor;

  logic        clk = 1'b0;
  logic        rst;
  logic        initBusy;
  logic        predValid;
  logic [31:0] predPC;
  logic [1:0]  predCondBr;
  logic        predOutValid;
  logic [1:0]  predTaken;
  logic [7:0]  predHist;
  logic [3:0]  predCnt;
  logic [1:0]  updValid, updTaken, updMispred;
  logic [63:0] updPC;
  logic [7:0]  updHist;
  logic [3:0]  updCnt;
`ifdef LOCAL_PRED_STATS_EN
  logic [31:0] statPredNum, statMispredNum;
`endif

  local_hist_predictor dut (
    .clk(clk), .rst(rst), .initBusy(initBusy),
    .predValid(predValid), .predPC(predPC), .predCondBr(predCondBr),
    .predOutValid(predOutValid), .predTaken(predTaken), .predHist(predHist),
    .predCnt(predCnt),
`ifdef LOCAL_PRED_STATS_EN
    .statPredNum(statPredNum), .statMispredNum(statMispredNum),
`endif
    .updValid(updValid), .updPC(updPC), .updTaken(updTaken),
    .updMispred(updMispred), .updHist(updHist), .updCnt(updCnt)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: counters and histories as plain integers.
  int m_pht [1024];
  int m_bht [256];

  bit         exp_valid;
  logic [1:0] exp_taken;
  logic [7:0] exp_hist;
  logic [3:0] exp_cnt;

  function automatic int bidx(logic [31:0] pc);
    return int'((pc / 4) % 256);
  endfunction

  function automatic int pidx(logic [31:0] pc, int h);
    return int'((pc / 4) % 64) * 16 + h;
  endfunction

  task automatic chk(string tag, logic [63:0] observed, logic [63:0] expected);
    n_checks++;
    assert (observed === expected) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic model_init();
    for (int i = 0; i < 1024; i++) m_pht[i] = 2;
    for (int i = 0; i < 256; i++) m_bht[i] = 0;
  endtask

  task automatic idle();
    predValid = 0; predPC = 0; predCondBr = 0;
    updValid = 0; updPC = 0; updTaken = 0; updMispred = 0; updHist = 0; updCnt = 0;
  endtask

  task automatic set_lane(int k, bit v, logic [31:0] pc, bit t, bit m,
                          logic [3:0] h, logic [1:0] c);
    updValid[k] = v; updPC[k*32 +: 32] = pc; updTaken[k] = t;
    updMispred[k] = m; updHist[k*4 +: 4] = h; updCnt[k*2 +: 2] = c;
  endtask

  task automatic predict(logic [31:0] pc, logic [1:0] cb);
    predValid = 1; predPC = pc; predCondBr = cb;
  endtask

  // Counts cycles until initBusy drops, bounded.
  task automatic wait_init(output int n);
    n = 0;
    while (initBusy === 1'b1 && n < 5000) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  // One READY-state cycle: predict with the model, advance the model,
  // clock the DUT, compare the registered outputs.
  task automatic tick();
    int view [256];
    int h, c, bi, idx, v;
    bit tk, seen, dup;
    logic [31:0] spc, lpc, jpc;
    exp_valid = predValid;
    view = m_bht;
    seen = 0;
    if (predValid) begin
      for (int s = 0; s < 2; s++) begin
        spc = predPC + 32'(s * 4);
        bi  = bidx(spc);
        h   = view[bi];
        c   = m_pht[pidx(spc, h)];
        tk  = predCondBr[s] && (c >= 2);
        exp_taken[s]       = tk;
        exp_hist[s*4 +: 4] = 4'(h);
        exp_cnt[s*2 +: 2]  = 2'(c);
        if (predCondBr[s] && !seen) view[bi] = (h * 2 + int'(tk)) % 16;
        if (tk) seen = 1;
      end
    end
    for (int k = 0; k < 2; k++) begin
      if (updValid[k]) begin
        lpc = updPC[k*32 +: 32];
        idx = pidx(lpc, int'(updHist[k*4 +: 4]));
        dup = 0;
        for (int j = 0; j < k; j++) begin
          jpc = updPC[j*32 +: 32];
          if (updValid[j] && pidx(jpc, int'(updHist[j*4 +: 4])) == idx) dup = 1;
        end
        if (!dup) begin
          v = int'(updCnt[k*2 +: 2]);
          m_pht[idx] = updTaken[k] ? ((v + 1 > 3) ? 3 : v + 1) : ((v - 1 < 0) ? 0 : v - 1);
        end
      end
    end
    m_bht = view;
    for (int k = 0; k < 2; k++) begin
      if (updValid[k] && updMispred[k]) begin
        lpc = updPC[k*32 +: 32];
        m_bht[bidx(lpc)] = (int'(updHist[k*4 +: 4]) * 2 + int'(updTaken[k])) % 16;
      end
    end
    @(posedge clk); #1;
    chk("predOutValid", 64'(predOutValid), 64'(exp_valid));
    if (exp_valid) begin
      chk("predTaken", 64'(predTaken), 64'(exp_taken));
      chk("predHist", 64'(predHist), 64'(exp_hist));
      chk("predCnt", 64'(predCnt), 64'(exp_cnt));
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    idle();
    rst = 1;
    @(posedge clk); #1;
    chk("rst_initBusy", 64'(initBusy), 64'd1);
    chk("rst_predOutValid", 64'(predOutValid), 64'd0);
    chk("rst_predTaken", 64'(predTaken), 64'd0);
    chk("rst_predHist", 64'(predHist), 64'd0);
    chk("rst_predCnt", 64'(predCnt), 64'd0);
    rst = 0;
    wait_init(n);
    chk("init_cycles", 64'(n), 64'd1024);
    model_init();

    // Freshly initialised tables read weakly taken with zero history.
    predict(32'h300, 2'b00); tick();
    chk("init_cnt", 64'(predCnt), 64'h a);
    chk("init_hist", 64'(predHist), 64'd0);

    // Basic prediction and speculative history.
    predict(32'h100, 2'b01); tick();
    chk("basic_taken", 64'(predTaken), 64'b01);
    chk("basic_hist0", 64'(predHist[3:0]), 64'b0000);
    tick();
    chk("basic_hist1", 64'(predHist[3:0]), 64'b0001);

    // Slot 0 taken: slot 1 history must not be shifted.
    predict(32'h100, 2'b11); tick();
    predict(32'h100, 2'b00); tick();
    chk("cutoff_slot1", 64'(predHist[7:4]), 64'b0000);
    chk("cutoff_slot0", 64'(predHist[3:0]), 64'b0111);

    // Saturation at both ends.
    idle();
    set_lane(0, 1, 32'h204, 1, 0, 4'b0000, 2'd3);
    repeat (3) tick();
    idle(); predict(32'h204, 2'b00); tick();
    chk("sat_high", 64'(predCnt[1:0]), 64'd3);
    idle(); set_lane(0, 1, 32'h204, 0, 0, 4'b0000, 2'd0); tick();
    idle(); predict(32'h204, 2'b00); tick();
    chk("sat_low", 64'(predCnt[1:0]), 64'd0);

    // Two lanes on one PHT entry: lane 0 wins.
    idle();
    set_lane(0, 1, 32'h208, 1, 0, 4'b0000, 2'd0);
    set_lane(1, 1, 32'h208, 1, 0, 4'b0000, 2'd2);
    tick();
    idle(); predict(32'h208, 2'b00); tick();
    chk("pht_conflict", 64'(predCnt[1:0]), 64'd1);

    // Recovery overrides a same-cycle speculative shift.
    idle(); predict(32'h20c, 2'b01);
    set_lane(0, 1, 32'h20c, 0, 1, 4'b1011, 2'd1);
    tick();
    idle(); predict(32'h20c, 2'b00); tick();
    chk("recovery", 64'(predHist[3:0]), 64'b0110);

    // Highest recovering lane wins.
    idle();
    set_lane(0, 1, 32'h210, 1, 1, 4'b0000, 2'd1);
    set_lane(1, 1, 32'h210, 0, 1, 4'b1111, 2'd1);
    tick();
    idle(); predict(32'h210, 2'b00); tick();
    chk("lane_priority", 64'(predHist[3:0]), 64'b1110);

    // Random traffic over a small PC pool so entries collide.
    for (int it = 0; it < 400; it++) begin
      predValid  = ($urandom_range(0, 3) != 0);
      predPC     = 32'h100 + 32'($urandom_range(0, 15)) * 4;
      predCondBr = 2'($urandom_range(0, 3));
      for (int k = 0; k < 2; k++) begin
        bit v;
        v = 1'($urandom_range(0, 1));
        set_lane(k, v, 32'h100 + 32'($urandom_range(0, 15)) * 4, 1'($urandom_range(0, 1)),
                 v & 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
                 2'($urandom_range(0, 3)));
      end
      if ($urandom_range(0, 3) == 0) begin
        updPC[63:32] = updPC[31:0];
        updHist[7:4] = updHist[3:0];
      end
      tick();
    end

    // Reset in the middle of INIT: predictions and updates are ignored,
    // and INIT restarts from entry 0.
    idle();
    rst = 1;
    @(posedge clk); #1;
    rst = 0;
    predict(32'h204, 2'b01);
    set_lane(0, 1, 32'h204, 1, 1, 4'b0000, 2'd3);
    for (int c = 0; c < 500; c++) begin
      @(posedge clk); #1;
      chk("init_no_pred", 64'(predOutValid), 64'd0);
    end
    chk("mid_init_busy", 64'(initBusy), 64'd1);
    rst = 1;
    @(posedge clk); #1;
    rst = 0;
    idle();
    wait_init(n);
    chk("reinit_cycles", 64'(n), 64'd1024);
    model_init();
    predict(32'h204, 2'b00); tick();
    chk("reinit_cnt", 64'(predCnt[1:0]), 64'd2);
    chk("reinit_hist", 64'(predHist[3:0]), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/local_hist_predictor.md
Name: local_hist_predictor

Overview:
- Parametrised per-address two-level (PAs-class) conditional branch direction predictor for the fetch unit.
- Branch history table (BHT) of per-PC local histories selects a saturating counter in a pattern history table (PHT).
- Generalised in fetch/update width, history length, table depths and counter width; adds a reset-init FSM, registered prediction outputs, in-order history chaining and defined write-conflict priority.

Parameters:
FETCH_WIDTH, 2, prediction slots per cycle (consecutive instructions)
UPDATE_WIDTH, 2, branch-resolution lanes per cycle
BHT_INDEX_BITS, 8, log2 BHT entries
HIST_LEN, 4, local history bits per entry (>=2, < PHT_INDEX_BITS)
PHT_INDEX_BITS, 10, log2 PHT entries
CNT_WIDTH, 2, counter width (>=2)
PC_WIDTH, 32, address width
INSN_SHIFT, 2, log2 instruction bytes

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
initBusy  out  1  table initialisation in progress
predValid  in  1  fetch request valid
predPC  in  PC_WIDTH  PC of slot 0; slot i = predPC + i<<INSN_SHIFT
predCondBr  in  FETCH_WIDTH  slot i is a BTB-hit conditional branch
predOutValid  out  1  prediction outputs valid
predTaken  out  FETCH_WIDTH  predicted taken per slot
predHist  out  FETCH_WIDTH*HIST_LEN  history used per slot (carried down pipe)
predCnt  out  FETCH_WIDTH*CNT_WIDTH  counter value read per slot
updValid  in  UPDATE_WIDTH  resolved conditional branch per lane
updPC  in  UPDATE_WIDTH*PC_WIDTH  branch address
updTaken  in  UPDATE_WIDTH  actual direction
updMispred  in  UPDATE_WIDTH  direction mispredicted
updHist  in  UPDATE_WIDTH*HIST_LEN  predHist carried with branch
updCnt  in  UPDATE_WIDTH*CNT_WIDTH  predCnt carried with branch

Behaviour:
- Indexing: bhtIdx = pc[INSN_SHIFT +: BHT_INDEX_BITS]; phtIdx = {pc[INSN_SHIFT +: PHT_INDEX_BITS-HIST_LEN], hist}.
- FSM INIT/READY. rst (any state, including mid-INIT) -> INIT, initIdx=0. INIT: each cycle PHT[initIdx] = 2^(CNT_WIDTH-1) (weakly taken), BHT[initIdx] = 0 when initIdx < 2^BHT_INDEX_BITS; initIdx++. Exit to READY after max(2^PHT_INDEX_BITS, 2^BHT_INDEX_BITS) cycles.
- INIT: initBusy=1, predOutValid=0, updates dropped.
- Reset values: initBusy=1, predOutValid=0, predTaken=0, predHist=0, predCnt=0.
- Prediction, latency 1: predValid sampled in READY at cycle N -> outputs at N+1. Tables read with state at start of N; same-cycle writes are not bypassed.
- Slot i: predTaken[i] = counter MSB & predCondBr[i].
- Speculative history shift at end of N, in slot order, for slots with predCondBr up to and including the first predicted-taken slot: BHT = {hist[HIST_LEN-2:0], predTaken}. Later slots are not shifted.
- Two slots mapping to the same BHT entry chain: the later slot reads the earlier slot's shifted history and its counter is indexed accordingly.
- predOutValid=0 in cycle N+1 when predValid=0 in cycle N.
- Update, applied at end of cycle: lane k writes PHT[{updPC, updHist}] = updTaken ? min(updCnt+1, max) : max(updCnt-1, 0). Saturates at 2^CNT_WIDTH-1 and 0.
- Same PHT index on multiple lanes: lowest lane writes, others dropped.
- updMispred lane: BHT[bhtIdx(updPC)] = {updHist[HIST_LEN-2:0], updTaken}.
- BHT priority on the same entry in one cycle: highest-lane recovery > lower-lane recovery > speculative shift.

Optional Feature:
LOCAL_PRED_STATS_EN: adds outputs statPredNum and statMispredNum (32 bits each, wrapping). They count predicted conditional slots and updMispred lanes, and are cleared by rst. Without the macro the ports and logic are absent, with no other change.

Decomposition:
- Package LocalPredTypes holds:
  - BhtIndexPath, PhtIndexPath, LocalHistPath and PhtCounter typedefs
  - InitState enum
  - index functions ToBhtIndex and ToPhtIndex
  - SatInc and SatDec
- Sub-module local_pred_init_seq: INIT/READY FSM and initIdx counter, outputting initBusy, initWE and initIdx.

Test Plan:
- Init timing: rst 1 cycle -> initBusy=1 for exactly 1024 cycles, then 0. All predCnt read = 2, predHist = 0.
- Reset mid-INIT: rst at initIdx=500 -> initIdx restarts at 0, initBusy lasts a further 1024 cycles.
- Basic predict and history: predPC=0x100, predCondBr=2'b01 -> next cycle predTaken=01, predHist[0]=0000. Repeat -> predHist[0]=0001.
- Taken-slot cutoff: predCondBr=11 with slot 0 taken -> slot 1 BHT entry unchanged.
- Saturation: 3 taken updates with updCnt=3 -> PHT entry stays 3. Not-taken with updCnt=0 -> stays 0.
- Conflict and recovery: two lanes with the same PHT index -> only lane 0 value written. updMispred, updHist=1011, updTaken=0 -> BHT entry = 0110, overriding a same-cycle speculative shift.
